// File: rtl/booth_pkg.sv
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and constants for the radix-4 Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_digit_t;

    // A radix-4 digit is recoded from three overlapping multiplier bits.
    function automatic int booth_triplet_width();
        return 3;
    endfunction

    localparam int c_triplet_w = booth_triplet_width();

endpackage

`default_nettype wire

// File: rtl/booth_r4_digit_enc.sv
// ============================================================================
// Module      : booth_r4_digit_enc
// Description : Combinational radix-4 Booth digit encoder (triplet -> neg/two/one).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_r4_digit_enc
    import booth_pkg::*;
(
    input  logic [c_triplet_w-1:0] i_triplet,
    output booth_digit_t           o_digit
);

    logic w_x2;
    logic w_x1;
    logic w_x0;

    assign w_x2 = i_triplet[2];
    assign w_x1 = i_triplet[1];
    assign w_x0 = i_triplet[0];

    assign o_digit.one = w_x1 ^ w_x0;
    assign o_digit.two = (w_x2 & ~w_x1 & ~w_x0) | (~w_x2 & w_x1 & w_x0);
    // Triplet 111 encodes zero and must not be reported as negative.
    assign o_digit.neg = w_x2 & ~(w_x1 & w_x0);

endmodule

`default_nettype wire

// File: rtl/booth_r4_seq_mult.sv
// ============================================================================
// Module      : booth_r4_seq_mult
// Description : Sequential radix-4 Booth multiplier, one digit per clock, with
//               valid/ready handshakes. Macro BOOTH_APPROX_EN zeroes the lowest
//               APPROX_DIGITS Booth digits (approximate mode).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int APPROX_DIGITS = 1
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int c_idx_w = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
    localparam int c_pp_w  = WIDTH + 2;
    localparam int c_acc_w = 2 * WIDTH;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WIDTH / 2 - 1);

`ifdef BOOTH_APPROX_EN
    localparam bit c_approx_en = 1'b1;
`else
    localparam bit c_approx_en = 1'b0;
`endif

    booth_state_t         r_state;
    booth_state_t         w_state_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [c_acc_w-1:0]   r_acc;
    logic [c_idx_w-1:0]   r_idx;

    logic [WIDTH:0]       w_bext;
    logic [c_triplet_w-1:0] w_triplet;
    booth_digit_t         w_enc;
    booth_digit_t         w_dig;
    logic                 w_zero;
    logic [c_pp_w-1:0]    w_a_ext;
    logic [c_pp_w-1:0]    w_mag;
    logic [c_pp_w-1:0]    w_pp;
    logic [c_acc_w-1:0]   w_pp_ext;
    logic [c_acc_w-1:0]   w_pp_sh;
    logic                 w_accept;
    logic                 w_last;

    // Appending the implicit b[-1]=0 lets digit i start at bit 2i.
    assign w_bext    = {r_b, 1'b0};
    assign w_triplet = w_bext[{r_idx, 1'b0} +: c_triplet_w];

    booth_r4_digit_enc u_enc (
        .i_triplet (w_triplet),
        .o_digit   (w_enc)
    );

    assign w_zero = c_approx_en && (int'(r_idx) < APPROX_DIGITS);
    assign w_dig  = w_zero ? '0 : w_enc;

    assign w_a_ext = {{2{r_a[WIDTH-1]}}, r_a};

    always_comb begin
        w_mag = '0;
        if (w_dig.two) begin
            w_mag = w_a_ext << 1;
        end else if (w_dig.one) begin
            w_mag = w_a_ext;
        end
        w_pp = w_dig.neg ? -w_mag : w_mag;
    end

    assign w_pp_ext = {{(c_acc_w - c_pp_w){w_pp[c_pp_w-1]}}, w_pp};
    assign w_pp_sh  = w_pp_ext << {r_idx, 1'b0};

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_idx == c_last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_idx <= '0;
        end else if (r_state == RUN) begin
            r_acc <= r_acc + w_pp_sh;
            r_idx <= r_idx + 1'b1;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign p         = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
// ============================================================================
// Module      : tb_booth_r4_seq_mult
// Description : Scoreboard bench for booth_r4_seq_mult (directed corners + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_r4_seq_mult;

    localparam int W   = 8;
    localparam int AD  = 1;
    localparam int LAT = W / 2 + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     a;
    logic signed [W-1:0]     b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [2*W-1:0]   p;

    booth_r4_seq_mult #(.WIDTH(W), .APPROX_DIGITS(AD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0;
    logic signed [2*W-1:0] exp_q[$];
    int                    acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: a times the Booth value of b; approximate mode removes the
    // value of the dropped low digits, which equals the signed low 2k bits of b.
    function automatic logic signed [2*W-1:0] model(input logic signed [W-1:0] x,
                                                    input logic signed [W-1:0] y);
        longint pa = longint'(x);
        longint pb = longint'(y);
`ifdef BOOTH_APPROX_EN
        longint low;
        int k = (AD > W / 2) ? W / 2 : AD;
        if (k > 0) begin
            low = pb & ((longint'(1) << (2 * k)) - 1);
            if (low[2*k-1]) low = low - (longint'(1) << (2 * k));
            pb = pb - low;
        end
`endif
        return (2*W)'(pa * pb);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Input monitor: record every accepted operand pair.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(model(a, b));
            acc_q.push_back(cyc);
            n_acc++;
        end
    end

    // Output monitor: latency on rising out_valid, product on each handshake.
    logic prev_ov = 1'b0;
    logic hs_pend = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
            hs_pend = 1'b0;
        end else begin
            if (hs_pend) begin
                check("post_hs_out_valid", longint'(out_valid), 0);
                check("post_hs_in_ready", longint'(in_ready), 1);
                hs_pend = 1'b0;
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) fail_bound("spurious_out_valid");
                else check("latency", longint'(cyc - acc_q.pop_front()), LAT);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_bound("unexpected_product");
                else check("product", longint'(p), longint'(exp_q.pop_front()));
                hs_pend = 1'b1;
            end
            prev_ov = out_valid;
        end
    end

    task automatic issue(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
        int n = 0;
        @(posedge clk); #1;
        a = x;
        b = y;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) fail_bound("issue_accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || out_valid) && n < 200);
        if (exp_q.size() != 0 || out_valid) fail_bound("drain");
    endtask

    initial begin
        logic signed [2*W-1:0] p0;
        int n;
        int target;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_p", longint'(p), 0);

        issue(8'sd3, 8'sd5);          drain();
        issue(-8'sd128, -8'sd128);    drain();
        issue(8'sd127, -8'sd128);     drain();
        issue(8'sd0, -8'sd1);         drain();
        issue(8'sd7, 8'sd3);          drain();

        // Backpressure: product must hold and a pending request must wait.
        out_ready = 1'b0;
        issue(8'sd100, -8'sd3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) fail_bound("bp_out_valid");
        p0 = p;
        @(posedge clk); #1;
        a = 8'sd5;
        b = 8'sd5;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_p_stable", longint'(p), longint'(p0));
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_out_valid", longint'(out_valid), 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset in the middle of an operation discards it.
        issue(8'sd7, 8'sd9);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", longint'(in_ready), 1);
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_p", longint'(p), 0);
        issue(8'sd2, 8'sd2);
        drain();

        // Random operands with random in_valid/out_ready toggling.
        target = n_acc + 2000;
        n = 0;
        while (n_acc < target && n < 60000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1) != 0;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 15) == 0) a = -8'sd128;
            if ($urandom_range(0, 15) == 0) b = -8'sd128;
            n++;
        end
        in_valid = 1'b0;
        if (n_acc < target) fail_bound("random_accepts");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
